// File: rtl/cpu_accel_pkg.sv
// Shared definitions for the accelerator-side data-memory port.
//   state_t      : job sequencer states
//   BLK_MAX_ADDR : highest legal start address of the 64-byte source block
//   RES_MAX_ADDR : highest legal start address of the 9-word result area
//   STATUS_VAL   : word written after the result words
//   RES_WORDS    : number of 32-bit result words
package cpu_accel_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHK,
      RD,
      BLK,
      RES,
      WR,
      STAT
   } state_t;

   localparam logic [15:0] BLK_MAX_ADDR = 16'hFFC0;
   localparam logic [15:0] RES_MAX_ADDR = 16'hFFDC;
   localparam logic [31:0] STATUS_VAL   = 32'h1;
   localparam int unsigned RES_WORDS    = 8;

endpackage

// File: rtl/cpu_accel_wr_ser.sv
// Result serializer: holds the accelerator result and walks it out one
// 32-bit word at a time for write-back.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture res_in and restart at word 0
//   res_in     : full result, word k = bits[32k+31:32k]
//   adv        : step to the next word (granted write cycle)
//   word       : current word
//   offset     : byte offset of current word (4*k)
//   last       : current word is the final one
module cpu_accel_wr_ser
   import cpu_accel_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned N_WORDS = RES_WORDS
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [32*N_WORDS-1:0]   res_in,
   input  logic                    adv,
   output logic [31:0]             word,
   output logic [ADDR_W-1:0]       offset,
   output logic                    last
);

   localparam int unsigned IDX_W = $clog2(N_WORDS);

   logic [32*N_WORDS-1:0] res_q;
   logic [IDX_W-1:0]      idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
         idx   <= '0;
      end else if (load) begin
         res_q <= res_in;
         idx   <= '0;
      end else if (adv) begin
         idx   <= idx + IDX_W'(1);
      end
   end

   assign word   = res_q[{idx, 5'b00000} +: 32];
   assign offset = ADDR_W'({idx, 2'b00});
   assign last   = (idx == IDX_W'(N_WORDS - 1));

endmodule

// File: rtl/cpu_accel_mem_port.sv
// Accelerator-side data-memory initiator. On start it range-checks the two
// addresses, reads one 64-byte block in a single granted cycle, hands it to
// the accelerator, collects the 256-bit result and writes it back as
// RES_WORDS words followed by a status word.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   start, blk_addr, res_addr   : job launch pulse and its two byte addresses
//   busy, done, err             : job in flight / end pulse / range-error pulse
//   mem_req, mem_gnt            : arbiter request and grant
//   mem_addr, mem_wrt_data,
//   mem_wrt_en, mem_rd_data     : data-memory access (combinational read)
//   acc_blk, acc_blk_vld/rdy    : block to the accelerator
//   acc_res, acc_res_vld/rdy    : result from the accelerator
module cpu_accel_mem_port #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned RES_WORDS  = cpu_accel_pkg::RES_WORDS,
   parameter logic [31:0] STATUS_VAL = cpu_accel_pkg::STATUS_VAL
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     blk_addr,
   input  logic [ADDR_W-1:0]     res_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  mem_req,
   input  logic                  mem_gnt,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [31:0]           mem_wrt_data,
   output logic                  mem_wrt_en,
   input  logic [511:0]          mem_rd_data,
   output logic [511:0]          acc_blk,
   output logic                  acc_blk_vld,
   input  logic                  acc_blk_rdy,
   input  logic [255:0]          acc_res,
   input  logic                  acc_res_vld,
   output logic                  acc_res_rdy
);

   import cpu_accel_pkg::*;

   localparam logic [ADDR_W-1:0] BLK_LIM  = ADDR_W'(BLK_MAX_ADDR);
   localparam logic [ADDR_W-1:0] RES_LIM  = ADDR_W'(RES_MAX_ADDR);
   localparam logic [ADDR_W-1:0] STAT_OFF = ADDR_W'(4 * RES_WORDS);

   state_t              state;
   logic [ADDR_W-1:0]   blk_q;
   logic [ADDR_W-1:0]   res_q;

   logic                ser_load;
   logic                ser_adv;
   logic [31:0]         ser_word;
   logic [ADDR_W-1:0]   ser_off;
   logic                ser_last;

   assign ser_load = (state == RES) && acc_res_vld;
   assign ser_adv  = (state == WR)  && mem_gnt;

   cpu_accel_wr_ser #(
      .ADDR_W  (ADDR_W),
      .N_WORDS (RES_WORDS)
   ) u_wr_ser (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (ser_load),
      .res_in (acc_res),
      .adv    (ser_adv),
      .word   (ser_word),
      .offset (ser_off),
      .last   (ser_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         blk_q       <= '0;
         res_q       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         mem_req     <= 1'b0;
         acc_blk     <= '0;
         acc_blk_vld <= 1'b0;
         acc_res_rdy <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               // A start landing in the done cycle belongs to the finished job
               if (start && !done) begin
                  blk_q <= blk_addr;
                  res_q <= res_addr;
                  busy  <= 1'b1;
                  state <= CHK;
               end
            end
            CHK: begin
               if ((blk_q > BLK_LIM) || (res_q > RES_LIM)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  err   <= 1'b1;
                  state <= IDLE;
               end else begin
                  mem_req <= 1'b1;
                  state   <= RD;
               end
            end
            RD: begin
               if (mem_gnt) begin
                  acc_blk     <= mem_rd_data;
                  mem_req     <= 1'b0;
                  acc_blk_vld <= 1'b1;
                  state       <= BLK;
               end
            end
            BLK: begin
               if (acc_blk_rdy) begin
                  acc_blk_vld <= 1'b0;
                  acc_res_rdy <= 1'b1;
                  state       <= RES;
               end
            end
            RES: begin
               if (acc_res_vld) begin
                  acc_res_rdy <= 1'b0;
                  mem_req     <= 1'b1;
                  state       <= WR;
               end
            end
            WR: begin
               if (mem_gnt && ser_last) begin
                  state <= STAT;
               end
            end
            STAT: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Address/data decode from registered state only; zero outside access phases
   always_comb begin
      mem_addr     = '0;
      mem_wrt_data = '0;
      mem_wrt_en   = 1'b0;
      case (state)
         RD: begin
            mem_addr = blk_q;
         end
         WR: begin
            mem_addr     = res_q + ser_off;
            mem_wrt_data = ser_word;
            mem_wrt_en   = mem_gnt;
         end
         STAT: begin
            mem_addr     = res_q + STAT_OFF;
            mem_wrt_data = STATUS_VAL;
            mem_wrt_en   = mem_gnt;
         end
         default: ;
      endcase
   end

endmodule
